result_ascii_encoder: RTL

- Return path of the co-processor's host link: takes a signed 16-bit result from the arithmetic core and streams it to the UART transmitter as ASCII decimal text.
- Output format: optional '-', decimal digits with no leading zeros, then a terminator byte.
- A result flagged as an error (e.g. divide by zero) is sent as a single error character plus the terminator.
- One result in flight at a time; byte-level valid/ready handshake toward the transmitter.

---
 rtl/result_ascii_encoder.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/result_ascii_encoder.sv
// result_ascii_encoder: converts a signed 16-bit result into ASCII decimal text
// ('-', digits without leading zeros, terminator) or an error character plus
// terminator, and streams the bytes to a UART transmitter.
//
// Handshake: a byte moves on a rising edge where o_valid=1 and i_tx_ready=1.
// o_byte is held stable while o_valid=1 until that transfer; o_valid only drops
// after a transfer (or on reset). i_ready is a one-cycle strobe that is only
// honoured while o_busy=0.
module result_ascii_encoder #(
  parameter logic [7:0] MINUS_CHAR = 8'h2D,
  parameter logic [7:0] ERR_CHAR   = 8'h45,
  parameter logic [7:0] TERM_CHAR  = 8'h0A
) (
  input  logic        i_clk,
  input  logic        reset,
  input  logic        i_ready,
  input  logic [15:0] i_result,
  input  logic        i_err,
  input  logic        i_tx_ready,
  output logic        o_valid,
  output logic [7:0]  o_byte,
  output logic        o_busy
);

  typedef enum logic [2:0] {IDLE, CONV, SIGN, DIGIT, ERR, TERM} state_t;

  // state is kept as a named internal signal so checkers can bind to it
  state_t          state, state_n;
  logic            neg, neg_n;
  logic [15:0]     mag, mag_n;
  logic [2:0]      pidx, pidx_n;     // 0 -> 10000 ... 4 -> 1
  logic [2:0]      didx, didx_n;     // digit being emitted, 0 = ten-thousands
  logic [4:0][3:0] dig, dig_n;       // decimal digits, index 0 most significant
  logic            valid_n, busy_n;
  logic [7:0]      byte_n;
  logic [15:0]     pow;
  logic [2:0]      first;
  logic            xfer;

  assign xfer = o_valid & i_tx_ready;

  // Power of ten selected by the conversion index
  always_comb begin
    pow = 16'd1;
    case (pidx)
      3'd0:    pow = 16'd10000;
      3'd1:    pow = 16'd1000;
      3'd2:    pow = 16'd100;
      3'd3:    pow = 16'd10;
      default: pow = 16'd1;
    endcase
  end

  // Index of the first nonzero digit; the units digit is always emitted
  always_comb begin
    first = 3'd4;
    for (int i = 3; i >= 0; i--) begin
      if (dig[i] != 4'd0) first = i[2:0];
    end
  end

  // Next-state and next-output logic; outputs are registered below
  always_comb begin
    state_n = state;
    neg_n   = neg;
    mag_n   = mag;
    pidx_n  = pidx;
    didx_n  = didx;
    dig_n   = dig;
    valid_n = o_valid;
    byte_n  = o_byte;
    case (state)
      IDLE: begin
        if (i_ready) begin
          if (i_err) begin
            state_n = ERR;
            valid_n = 1'b1;
            byte_n  = ERR_CHAR;
          end else begin
            state_n = CONV;
            neg_n   = i_result[15];
            mag_n   = i_result[15] ? (~i_result + 16'd1) : i_result;
            pidx_n  = 3'd0;
            dig_n   = '0;
          end
        end
      end
      CONV: begin
        if (mag >= pow) begin
          mag_n       = mag - pow;
          dig_n[pidx] = dig[pidx] + 4'd1;
        end else if (pidx == 3'd4) begin
          valid_n = 1'b1;
          if (neg) begin
            state_n = SIGN;
            byte_n  = MINUS_CHAR;
          end else begin
            state_n = DIGIT;
            didx_n  = first;
            byte_n  = 8'h30 + {4'h0, dig[first]};
          end
        end else begin
          pidx_n = pidx + 3'd1;
        end
      end
      SIGN: begin
        if (xfer) begin
          state_n = DIGIT;
          didx_n  = first;
          byte_n  = 8'h30 + {4'h0, dig[first]};
        end
      end
      DIGIT: begin
        if (xfer) begin
          if (didx == 3'd4) begin
            state_n = TERM;
            byte_n  = TERM_CHAR;
          end else begin
            didx_n = didx + 3'd1;
            byte_n = 8'h30 + {4'h0, dig[didx + 3'd1]};
          end
        end
      end
      ERR: begin
        if (xfer) begin
          state_n = TERM;
          byte_n  = TERM_CHAR;
        end
      end
      TERM: begin
        if (xfer) begin
          state_n = IDLE;
          valid_n = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  // State, datapath and output registers with asynchronous reset
  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      neg     <= 1'b0;
      mag     <= 16'd0;
      pidx    <= 3'd0;
      didx    <= 3'd0;
      dig     <= '0;
      o_valid <= 1'b0;
      o_byte  <= 8'h00;
      o_busy  <= 1'b0;
    end else begin
      state   <= state_n;
      neg     <= neg_n;
      mag     <= mag_n;
      pidx    <= pidx_n;
      didx    <= didx_n;
      dig     <= dig_n;
      o_valid <= valid_n;
      o_byte  <= byte_n;
      o_busy  <= busy_n;
    end
  end

endmodule
